// File: rtl/pwm_capture.sv
// PWM receiver: synchronises an asynchronous PWM input, measures period and high time in clk
// cycles, derives integer duty percent with a restoring divider and flags a stuck input.
`timescale 1ns/1ps
//   state   | meaning
//   ARMED   | waiting for the first rising edge; partial period is discarded
//   MEASURE | measuring rise-to-rise periods, results go through the divider
//   STUCK   | no rising edge for 2^CNT_W-1 cycles; outputs report the static level
module pwm_capture #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             pwm_in,
   input  logic             clear,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic [6:0]       duty_pct,
   output logic             meas_valid,
   output logic             stuck,
   output logic             overrun
);
   localparam int NUM_W  = CNT_W + 7;
   localparam int STEP_W = $clog2(NUM_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {ARMED, MEASURE, STUCK} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_prev_q, s_prev_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       hcnt_q, hcnt_d;
   logic                   busy_q, busy_d;
   logic [STEP_W-1:0]      step_q, step_d;
   logic [NUM_W-1:0]       num_q, num_d;
   logic [CNT_W-1:0]       rem_q, rem_d;
   logic [CNT_W-1:0]       den_q, den_d;
   logic [5:0]             quo_q, quo_d;
   logic [CNT_W-1:0]       hsnap_q, hsnap_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_q, high_d;
   logic [6:0]             duty_q, duty_d;
   logic                   valid_q, valid_d;
   logic                   stuck_q, stuck_d;
   logic                   ovr_q, ovr_d;

   logic                   s, rise, fall;
   logic [CNT_W:0]         trial;
   logic                   ge;
   logic [CNT_W-1:0]       rem_step;
   logic [NUM_W-1:0]       num_init;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_prev_q;
   assign fall = ~s & s_prev_q;

   // One restoring step: bring down the next numerator bit, subtract if it fits.
   assign trial    = {rem_q, num_q[NUM_W-1]};
   assign ge       = trial >= {1'b0, den_q};
   assign rem_step = ge ? CNT_W'(trial - {1'b0, den_q}) : trial[CNT_W-1:0];
   assign num_init = NUM_W'(hcnt_q) * NUM_W'(100);

   always_comb begin
      state_d  = state_q;
      sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_prev_d = s;
      cnt_d    = rise ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
      hcnt_d   = rise ? CNT_W'(1) : ((s && hcnt_q != CNT_MAX) ? hcnt_q + CNT_W'(1) : hcnt_q);
      busy_d   = busy_q;
      step_d   = step_q;
      num_d    = num_q;
      rem_d    = rem_q;
      den_d    = den_q;
      quo_d    = quo_q;
      hsnap_d  = hsnap_q;
      period_d = period_q;
      high_d   = high_q;
      duty_d   = duty_q;
      valid_d  = 1'b0;
      stuck_d  = stuck_q;
      ovr_d    = ovr_q;

      if (busy_q) begin
         rem_d  = rem_step;
         num_d  = num_q << 1;
         quo_d  = {quo_q[4:0], ge};
         step_d = step_q - STEP_W'(1);
         if (step_q == STEP_W'(1)) begin
            busy_d   = 1'b0;
            period_d = den_q;
            high_d   = hsnap_q;
            duty_d   = {quo_q, ge};
            valid_d  = 1'b1;
         end
      end

      case (state_q)
         ARMED: begin
            if (rise) state_d = MEASURE;
         end
         MEASURE: begin
            // Stuck detection overrides both a pending division and a coincident rise.
            if (cnt_q == CNT_MAX) begin
               state_d  = STUCK;
               stuck_d  = 1'b1;
               period_d = '0;
               high_d   = '0;
               duty_d   = s ? 7'd100 : 7'd0;
               valid_d  = 1'b1;
               busy_d   = 1'b0;
            end else if (rise) begin
               if (!busy_q) begin
                  busy_d  = 1'b1;
                  step_d  = STEP_W'(NUM_W);
                  num_d   = num_init;
                  rem_d   = '0;
                  quo_d   = '0;
                  den_d   = cnt_q;
                  hsnap_d = hcnt_q;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         STUCK: begin
            if (rise) begin
               stuck_d = 1'b0;
               state_d = MEASURE;
            end else if (fall) begin
               duty_d  = 7'd0;
               valid_d = 1'b1;
            end
         end
         default: state_d = ARMED;
      endcase

      if (clear) begin
         state_d  = ARMED;
         sync_d   = '0;
         s_prev_d = 1'b0;
         cnt_d    = '0;
         hcnt_d   = '0;
         busy_d   = 1'b0;
         step_d   = '0;
         num_d    = '0;
         rem_d    = '0;
         den_d    = '0;
         quo_d    = '0;
         hsnap_d  = '0;
         period_d = '0;
         high_d   = '0;
         duty_d   = '0;
         valid_d  = 1'b0;
         stuck_d  = 1'b0;
         ovr_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ARMED;
         sync_q   <= '0;
         s_prev_q <= 1'b0;
         cnt_q    <= '0;
         hcnt_q   <= '0;
         busy_q   <= 1'b0;
         step_q   <= '0;
         num_q    <= '0;
         rem_q    <= '0;
         den_q    <= '0;
         quo_q    <= '0;
         hsnap_q  <= '0;
         period_q <= '0;
         high_q   <= '0;
         duty_q   <= '0;
         valid_q  <= 1'b0;
         stuck_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         s_prev_q <= s_prev_d;
         cnt_q    <= cnt_d;
         hcnt_q   <= hcnt_d;
         busy_q   <= busy_d;
         step_q   <= step_d;
         num_q    <= num_d;
         rem_q    <= rem_d;
         den_q    <= den_d;
         quo_q    <= quo_d;
         hsnap_q  <= hsnap_d;
         period_q <= period_d;
         high_q   <= high_d;
         duty_q   <= duty_d;
         valid_q  <= valid_d;
         stuck_q  <= stuck_d;
         ovr_q    <= ovr_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_q;
   assign duty_pct   = duty_q;
   assign meas_valid = valid_q;
   assign stuck      = stuck_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of steady PWM patterns plus hand sequences for stuck, reset and clear;
// every meas_valid is checked against a timestamp-driven model through a scoreboard queue.
`timescale 1ns/1ps
module tb_pwm_capture;
   localparam int CNT_W     = 8;
   localparam int LAT       = CNT_W + 8;
   localparam int STUCK_LAT = (1 << CNT_W) + 2;

   typedef struct {
      int per;
      int hi;
      int n;
      int exp_duty;
      int exp_ovr;
   } vec_t;

   typedef struct {
      int per;
      int hi;
      int duty;
      int cyc;
   } exp_t;

   logic             clk;
   logic             rstn;
   logic             pwm_in;
   logic             clear;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic [6:0]       duty_pct;
   logic             meas_valid;
   logic             stuck;
   logic             overrun;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sbq[$];

   int m_state = 0;
   int m_ovr = 0;
   int last_rise = -1000;
   int last_fall = -1000;
   int last_start = -1000;

   pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .pwm_in     (pwm_in),
      .clear      (clear),
      .period     (period),
      .high_time  (high_time),
      .duty_pct   (duty_pct),
      .meas_valid (meas_valid),
      .stuck      (stuck),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rstn && meas_valid) begin
         tests++;
         if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_meas_valid: cycle %0d period=%0d high=%0d duty=%0d, none expected",
                     cyc, period, high_time, duty_pct);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if (int'(period) != e.per || int'(high_time) != e.hi || int'(duty_pct) != e.duty || cyc != e.cyc) begin
               fails++;
               $display("FAIL meas: got p=%0d h=%0d d=%0d at cycle %0d, expected p=%0d h=%0d d=%0d at cycle %0d",
                        period, high_time, duty_pct, cyc, e.per, e.hi, e.duty, e.cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_state    = 0;
      m_ovr      = 0;
      last_rise  = -1000;
      last_fall  = -1000;
      last_start = -1000;
   endtask

   // Drive pwm_in and predict what the receiver must report, from the drive timestamps alone.
   task automatic drive(input logic v);
      int   n;
      exp_t e;
      n = cyc;
      if (v && !pwm_in) begin
         if (m_state == 1) begin
            if (n - last_start >= LAT) begin
               e.per  = n - last_rise;
               e.hi   = last_fall - last_rise;
               e.duty = (e.hi * 100) / e.per;
               e.cyc  = n + LAT + 2;
               sbq.push_back(e);
               last_start = n;
            end else begin
               m_ovr = 1;
            end
         end
         m_state   = 1;
         last_rise = n;
      end else if (!v && pwm_in) begin
         last_fall = n;
         if (m_state == 2) begin
            e = '{per: 0, hi: 0, duty: 0, cyc: n + 3};
            sbq.push_back(e);
         end
      end
      pwm_in = v;
   endtask

   task automatic pulse_train(input int per, input int hi, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1);
         repeat (hi) tick();
         drive(1'b0);
         repeat (per - hi) tick();
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 80) begin
         tick();
         t++;
      end
      chk("drain_empty", sbq.size(), 0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_reset();
   endtask

   // Hold the line high after the current rise until the stuck detector fires.
   task automatic hold_high_until_stuck();
      exp_t e;
      drive(1'b1);
      e = '{per: 0, hi: 0, duty: 100, cyc: last_rise + STUCK_LAT};
      sbq.push_back(e);
      m_state = 2;
      repeat (STUCK_LAT + 12) tick();
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{per: 100, hi: 25,  n: 5,  exp_duty: 25, exp_ovr: 0};
      vecs[1] = '{per: 200, hi: 50,  n: 3,  exp_duty: 25, exp_ovr: 0};
      vecs[2] = '{per: 3,   hi: 1,   n: 30, exp_duty: 33, exp_ovr: 1};
      vecs[3] = '{per: 16,  hi: 8,   n: 5,  exp_duty: 50, exp_ovr: 0};
      vecs[4] = '{per: 17,  hi: 16,  n: 4,  exp_duty: 94, exp_ovr: 0};
      vecs[5] = '{per: 254, hi: 1,   n: 3,  exp_duty: 0,  exp_ovr: 0};
      vecs[6] = '{per: 7,   hi: 3,   n: 20, exp_duty: 42, exp_ovr: 1};
      vecs[7] = '{per: 50,  hi: 49,  n: 4,  exp_duty: 98, exp_ovr: 0};

      rstn   = 1'b0;
      pwm_in = 1'b0;
      clear  = 1'b0;
      repeat (3) tick();
      chk("rst_period", int'(period), 0);
      chk("rst_high", int'(high_time), 0);
      chk("rst_duty", int'(duty_pct), 0);
      chk("rst_valid", int'(meas_valid), 0);
      chk("rst_stuck", int'(stuck), 0);
      chk("rst_overrun", int'(overrun), 0);
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         do_clear();
         pulse_train(vecs[i].per, vecs[i].hi, vecs[i].n);
         drain();
         chk($sformatf("vec%0d_period", i), int'(period), vecs[i].per);
         chk($sformatf("vec%0d_high", i), int'(high_time), vecs[i].hi);
         chk($sformatf("vec%0d_duty", i), int'(duty_pct), vecs[i].exp_duty);
         chk($sformatf("vec%0d_overrun", i), int'(overrun), vecs[i].exp_ovr);
      end

      // Duty change 25 -> 75 at period 200.
      do_clear();
      pulse_train(200, 50, 3);
      pulse_train(200, 150, 3);
      drain();
      chk("dc_period", int'(period), 200);
      chk("dc_high", int'(high_time), 150);
      chk("dc_duty", int'(duty_pct), 75);

      // Stuck high, release low, then resume.
      do_clear();
      pulse_train(100, 25, 3);
      hold_high_until_stuck();
      chk("stk_stuck", int'(stuck), 1);
      chk("stk_period", int'(period), 0);
      chk("stk_high", int'(high_time), 0);
      chk("stk_duty_hi", int'(duty_pct), 100);
      drive(1'b0);
      repeat (10) tick();
      chk("stk_duty_lo", int'(duty_pct), 0);
      chk("stk_still", int'(stuck), 1);
      pulse_train(100, 25, 3);
      drain();
      chk("stk_resume_stuck", int'(stuck), 0);
      chk("stk_resume_duty", int'(duty_pct), 25);
      chk("stk_resume_period", int'(period), 100);

      // Async reset ten cycles into a division.
      do_clear();
      pulse_train(100, 5, 1);
      drive(1'b1);
      repeat (5) tick();
      drive(1'b0);
      repeat (8) tick();
      rstn = 1'b0;
      #1;
      sbq.delete();
      model_reset();
      chk("arst_period", int'(period), 0);
      chk("arst_high", int'(high_time), 0);
      chk("arst_duty", int'(duty_pct), 0);
      chk("arst_valid", int'(meas_valid), 0);
      repeat (3) tick();
      rstn = 1'b1;
      repeat (40) tick();
      pulse_train(100, 25, 3);
      drain();
      chk("arst_after_duty", int'(duty_pct), 25);

      // Clear while both overrun and stuck are set.
      do_clear();
      pulse_train(3, 1, 10);
      hold_high_until_stuck();
      drive(1'b0);
      repeat (6) tick();
      chk("clr_pre_stuck", int'(stuck), 1);
      chk("clr_pre_overrun", int'(overrun), 1);
      do_clear();
      chk("clr_stuck", int'(stuck), 0);
      chk("clr_overrun", int'(overrun), 0);
      chk("clr_period", int'(period), 0);
      chk("clr_duty", int'(duty_pct), 0);
      pulse_train(100, 25, 3);
      drain();
      chk("clr_after_duty", int'(duty_pct), 25);
      chk("clr_after_overrun", int'(overrun), 0);

      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
